// File: rtl/dispatch_queue.sv
// In-order dispatch queue: circular buffer of decoded instruction records, head issued when its FU is ready.
// Latency: a pushed record is visible at the head on the cycle after the push edge; issue is combinational on the head.
// Backpressure: stall_o when count >= DEPTH-1; pushes that still find no room are dropped and flag overflow_o (sticky).
module dispatch_queue #(
  parameter int DEPTH          = 4,
  parameter int regWidth       = 5,
  parameter int addressSize    = 64,
  parameter int opcodeWidth    = 6,
  parameter int XxoOpcodeWidth = 10,
  parameter int formatWidth    = 5
) (
  input  logic                          clock_i,
  input  logic                          resetn_i,
  input  logic                          enable_i,
  input  logic [63:0]                   imm_i,
  input  logic                          immEnable_i,
  input  logic [regWidth-1:0]           reg1_i,
  input  logic [regWidth-1:0]           reg2_i,
  input  logic [regWidth-1:0]           reg3_i,
  input  logic                          reg1Enable_i,
  input  logic                          reg2Enable_i,
  input  logic                          reg3Enable_i,
  input  logic                          reg3IsImmediate_i,
  input  logic                          reg2ValOrZero_i,
  input  logic                          bit1_i,
  input  logic                          bit2_i,
  input  logic                          bit1Enable_i,
  input  logic                          bit2Enable_i,
  input  logic [addressSize-1:0]        instructionAddress_i,
  input  logic [opcodeWidth-1:0]        opcode_i,
  input  logic [XxoOpcodeWidth-1:0]     xOpcode_i,
  input  logic                          xOpcodeEnable_i,
  input  logic [2:0]                    functionalUnitCode_i,
  input  logic [formatWidth-1:0]        instructionFormat_i,
  input  logic                          flush_i,
  input  logic [7:0]                    fuReady_i,
  output logic                          stall_o,
  output logic                          issueValid_o,
  output logic [63:0]                   imm_o,
  output logic                          immEnable_o,
  output logic [regWidth-1:0]           reg1_o,
  output logic [regWidth-1:0]           reg2_o,
  output logic [regWidth-1:0]           reg3_o,
  output logic                          reg1Enable_o,
  output logic                          reg2Enable_o,
  output logic                          reg3Enable_o,
  output logic                          reg3IsImmediate_o,
  output logic                          reg2ValOrZero_o,
  output logic                          bit1_o,
  output logic                          bit2_o,
  output logic                          bit1Enable_o,
  output logic                          bit2Enable_o,
  output logic [addressSize-1:0]        instructionAddress_o,
  output logic [opcodeWidth-1:0]        opcode_o,
  output logic [XxoOpcodeWidth-1:0]     xOpcode_o,
  output logic                          xOpcodeEnable_o,
  output logic [2:0]                    functionalUnitCode_o,
  output logic [formatWidth-1:0]        instructionFormat_o,
  output logic                          issueFire_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          overflow_o
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int REC_W = 64 + 1 + 3*regWidth + 3 + 2 + 4 + addressSize
                       + opcodeWidth + XxoOpcodeWidth + 1 + 3 + formatWidth;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [REC_W-1:0] wr_rec, head_rec;
  logic             push_ok, drop;

  assign wr_rec = {imm_i, immEnable_i, reg1_i, reg2_i, reg3_i,
                   reg1Enable_i, reg2Enable_i, reg3Enable_i,
                   reg3IsImmediate_i, reg2ValOrZero_i,
                   bit1_i, bit2_i, bit1Enable_i, bit2Enable_i,
                   instructionAddress_i, opcode_i, xOpcode_i, xOpcodeEnable_i,
                   functionalUnitCode_i, instructionFormat_i};

  assign head_rec = mem_q[rd_ptr_q];

  assign {imm_o, immEnable_o, reg1_o, reg2_o, reg3_o,
          reg1Enable_o, reg2Enable_o, reg3Enable_o,
          reg3IsImmediate_o, reg2ValOrZero_o,
          bit1_o, bit2_o, bit1Enable_o, bit2Enable_o,
          instructionAddress_o, opcode_o, xOpcode_o, xOpcodeEnable_o,
          functionalUnitCode_o, instructionFormat_o} = head_rec;

  // Head presentation and issue; a flush hides the head so nothing escapes in the flush cycle.
  assign issueValid_o = (count_q != '0) && !flush_i;
  assign issueFire_o  = issueValid_o && fuReady_i[functionalUnitCode_o];
  // A full queue can still accept when the head leaves on the same edge.
  assign push_ok      = enable_i && !flush_i && ((count_q < FULL_CNT) || issueFire_o);
  assign drop         = enable_i && !flush_i && !push_ok;
  assign stall_o      = (count_q >= STALL_CNT);
  assign count_o      = count_q;
  assign overflow_o   = overflow_q;

  // Next-state for pointers, occupancy and the sticky drop flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok)     wr_ptr_d = wr_ptr_q + 1'b1;
      if (issueFire_o) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !issueFire_o)      count_d = count_q + 1'b1;
      else if (!push_ok && issueFire_o) count_d = count_q - 1'b1;
      if (drop) overflow_d = 1'b1;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Record storage needs no reset; only accepted pushes write it.
  always_ff @(posedge clock_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_rec;
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Scoreboard bench for dispatch_queue (DEPTH=4): reference queue model, head/issue/count/overflow checks.
// Inputs driven just after the falling edge, outputs sampled 1 time unit later and after the next falling edge.
// Covers single issue, fill/stall/drop, full push+pop, head-of-line blocking, flush, random wrap traffic and async reset.
module tb_dispatch_queue;

  typedef struct packed {
    logic [63:0] imm;
    logic        imm_en;
    logic [4:0]  r1, r2, r3;
    logic        r1e, r2e, r3e, r3imm, r2vz, b1, b2, b1e, b2e;
    logic [63:0] addr;
    logic [5:0]  opc;
    logic [9:0]  xop;
    logic        xop_en;
    logic [2:0]  fu;
    logic [4:0]  fmt;
  } rec_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       en, flush;
  logic [7:0] rdy;
  rec_t       in_r, out_r;
  logic       stall, ivalid, ifire, ovf;
  logic [2:0] count;

  int   checks = 0;
  int   errors = 0;
  rec_t sb[$];
  int   m_count = 0;
  logic m_ovf = 1'b0;

  always #5 clk = ~clk;

  dispatch_queue #(.DEPTH(4)) dut (
    .clock_i(clk), .resetn_i(resetn), .enable_i(en),
    .imm_i(in_r.imm), .immEnable_i(in_r.imm_en),
    .reg1_i(in_r.r1), .reg2_i(in_r.r2), .reg3_i(in_r.r3),
    .reg1Enable_i(in_r.r1e), .reg2Enable_i(in_r.r2e), .reg3Enable_i(in_r.r3e),
    .reg3IsImmediate_i(in_r.r3imm), .reg2ValOrZero_i(in_r.r2vz),
    .bit1_i(in_r.b1), .bit2_i(in_r.b2), .bit1Enable_i(in_r.b1e), .bit2Enable_i(in_r.b2e),
    .instructionAddress_i(in_r.addr), .opcode_i(in_r.opc),
    .xOpcode_i(in_r.xop), .xOpcodeEnable_i(in_r.xop_en),
    .functionalUnitCode_i(in_r.fu), .instructionFormat_i(in_r.fmt),
    .flush_i(flush), .fuReady_i(rdy),
    .stall_o(stall), .issueValid_o(ivalid),
    .imm_o(out_r.imm), .immEnable_o(out_r.imm_en),
    .reg1_o(out_r.r1), .reg2_o(out_r.r2), .reg3_o(out_r.r3),
    .reg1Enable_o(out_r.r1e), .reg2Enable_o(out_r.r2e), .reg3Enable_o(out_r.r3e),
    .reg3IsImmediate_o(out_r.r3imm), .reg2ValOrZero_o(out_r.r2vz),
    .bit1_o(out_r.b1), .bit2_o(out_r.b2), .bit1Enable_o(out_r.b1e), .bit2Enable_o(out_r.b2e),
    .instructionAddress_o(out_r.addr), .opcode_o(out_r.opc),
    .xOpcode_o(out_r.xop), .xOpcodeEnable_o(out_r.xop_en),
    .functionalUnitCode_o(out_r.fu), .instructionFormat_o(out_r.fmt),
    .issueFire_o(ifire), .count_o(count), .overflow_o(ovf)
  );

  task automatic check_val(input string tag, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic rec_t rnd_rec(input logic [2:0] fu);
    logic [191:0] raw;
    rec_t r;
    raw = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    r = raw[177:0];
    r.fu = fu;
    return r;
  endfunction

  // One cycle: drive at the falling edge, check combinational outputs, advance model, check state after the edge.
  task automatic step(input logic e, input rec_t r, input logic fl, input logic [7:0] rd);
    logic exp_valid, exp_fire, push_ok;
    en = e; in_r = r; flush = fl; rdy = rd;
    #1;
    exp_valid = (m_count != 0) && !fl;
    exp_fire  = 1'b0;
    if (exp_valid && sb.size() > 0) exp_fire = rd[sb[0].fu];
    check_val("valid", 192'(ivalid), 192'(exp_valid));
    check_val("fire", 192'(ifire), 192'(exp_fire));
    check_val("stall", 192'(stall), 192'(m_count >= 3));
    if (exp_valid && sb.size() > 0) check_val("head", {14'b0, out_r}, {14'b0, sb[0]});
    if (fl) begin
      sb.delete();
    end else begin
      push_ok = e && ((m_count < 4) || exp_fire);
      if (exp_fire) void'(sb.pop_front());
      if (push_ok) sb.push_back(r);
      if (e && !push_ok) m_ovf = 1'b1;
    end
    m_count = sb.size();
    @(posedge clk);
    @(negedge clk);
    check_val("count", 192'(count), 192'(m_count));
    check_val("overflow", 192'(ovf), 192'(m_ovf));
  endtask

  // Asynchronous reset pulse between edges; outputs must clear with no clock edge.
  task automatic pulse_reset();
    #2;
    resetn = 1'b0;
    #1;
    check_val("rst_count", 192'(count), 192'd0);
    check_val("rst_valid", 192'(ivalid), 192'd0);
    check_val("rst_fire", 192'(ifire), 192'd0);
    check_val("rst_stall", 192'(stall), 192'd0);
    check_val("rst_ovf", 192'(ovf), 192'd0);
    sb.delete();
    m_count = 0;
    m_ovf = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) step(1'b0, rnd_rec(3'd0), 1'b0, 8'hff);
    check_val("drained", 192'(count), 192'd0);
  endtask

  initial begin
    resetn = 1'b0; en = 1'b0; flush = 1'b0; rdy = 8'h00; in_r = '0;
    @(negedge clk);
    @(negedge clk);
    check_val("init_count", 192'(count), 192'd0);
    check_val("init_valid", 192'(ivalid), 192'd0);
    check_val("init_stall", 192'(stall), 192'd0);
    check_val("init_ovf", 192'(ovf), 192'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Single entry: held while its FU is busy, issued when ready.
    step(1'b1, rnd_rec(3'd2), 1'b0, 8'h00);
    step(1'b0, rnd_rec(3'd0), 1'b0, 8'hfb);
    step(1'b0, rnd_rec(3'd0), 1'b0, 8'h04);

    // Fill, stall at 3, full at 4, fifth dropped.
    for (int i = 0; i < 5; i++) step(1'b1, rnd_rec(3'(i)), 1'b0, 8'h00);
    check_val("full_count", 192'(count), 192'd4);
    check_val("full_ovf", 192'(ovf), 192'd1);
    // Pop one to reach count 3, then flush with a simultaneous push.
    step(1'b0, rnd_rec(3'd0), 1'b0, 8'h01);
    step(1'b1, rnd_rec(3'd5), 1'b1, 8'hff);
    check_val("flush_ovf_kept", 192'(ovf), 192'd1);
    step(1'b0, rnd_rec(3'd0), 1'b0, 8'hff);

    // Full queue with the head ready: push and pop on one edge.
    pulse_reset();
    for (int i = 0; i < 4; i++) step(1'b1, rnd_rec(3'd0), 1'b0, 8'h00);
    step(1'b1, rnd_rec(3'd6), 1'b0, 8'h01);
    check_val("pp_count", 192'(count), 192'd4);
    check_val("pp_ovf", 192'(ovf), 192'd0);
    drain();

    // Head-of-line blocking: younger entry's FU ready must not bypass the head.
    step(1'b1, rnd_rec(3'd1), 1'b0, 8'h00);
    step(1'b1, rnd_rec(3'd3), 1'b0, 8'h00);
    step(1'b0, rnd_rec(3'd0), 1'b0, 8'h08);
    step(1'b0, rnd_rec(3'd0), 1'b0, 8'h02);
    step(1'b0, rnd_rec(3'd0), 1'b0, 8'h08);

    // Random traffic across pointer wrap, with an async reset mid-stream.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(1, 0)), rnd_rec(3'($urandom_range(7, 0))), 1'b0, 8'($urandom()));
      if (i == 30) pulse_reset();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
